// File: rtl/sha_pkg.sv
// Shared SHA types and helpers for the message-schedule block.
// Optional feature macro: SHA_SCHED_SHA1_EN (adds SHA-1 as a supported mode).
package sha;

  typedef enum logic [2:0] {
    SHA1   = 3'd0,
    SHA224 = 3'd1,
    SHA256 = 3'd2,
    SHA384 = 3'd3,
    SHA512 = 3'd4
  } mode_t;

  // One padded block, viewable as 32 x 32-bit or 16 x 64-bit words.
  typedef union packed {
    logic [31:0][31:0] w32;
    logic [15:0][63:0] w64;
  } msg_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  localparam int SCHED_WIN = 16;

  function automatic logic is64(mode_t m);
    return (m == SHA384) || (m == SHA512);
  endfunction

  function automatic logic [6:0] rounds(mode_t m);
    return ((m == SHA224) || (m == SHA256)) ? 7'd64 : 7'd80;
  endfunction

  function automatic logic mode_ok(mode_t m);
    case (m)
      SHA224, SHA256, SHA384, SHA512: mode_ok = 1'b1;
`ifdef SHA_SCHED_SHA1_EN
      SHA1: mode_ok = 1'b1;
`endif
      default: mode_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] delta0_32(logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] delta1_32(logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] delta0_64(logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] delta1_64(logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

endpackage

// File: rtl/sha_msg_schedule_word.sv
// Combinational next-word calculator for the message schedule.
// Optional feature macro: SHA_SCHED_SHA1_EN (builds the SHA-1 XOR/rotate path).
// Tap meaning (n = word index of tap_a):
//   SHA-2: a=W_n, b=W_(n+1), c=W_(n+9),  d=W_(n+14)
//   SHA-1: a=W_n, b=W_(n+2), c=W_(n+8),  d=W_(n+13)
module sha_sched_word
  import sha::*;
(
  input  logic [63:0] tap_a,
  input  logic [63:0] tap_b,
  input  logic [63:0] tap_c,
  input  logic [63:0] tap_d,
  input  mode_t       mode,
  output logic [63:0] word
);

  logic [31:0] s32;
  logic [63:0] s64;
`ifdef SHA_SCHED_SHA1_EN
  logic [31:0] x1;
`endif

  // Recurrence for the selected mode; 32-bit results are zero-extended.
  always_comb begin
    s32  = delta1_32(tap_d[31:0]) + tap_c[31:0] + delta0_32(tap_b[31:0]) + tap_a[31:0];
    s64  = delta1_64(tap_d) + tap_c + delta0_64(tap_b) + tap_a;
    word = is64(mode) ? s64 : {32'b0, s32};
`ifdef SHA_SCHED_SHA1_EN
    x1 = tap_a[31:0] ^ tap_b[31:0] ^ tap_c[31:0] ^ tap_d[31:0];
    if (mode == SHA1) word = {32'b0, x1[30:0], x1[31]};
`endif
  end

endmodule

// File: rtl/sha_msg_schedule.sv
// Streaming SHA message-schedule generator: one block in, W_t out, LANES words per beat.
// Optional feature macro: SHA_SCHED_SHA1_EN (SHA-1 mode, 80 rounds, 32-bit words).
// Handshake: a beat transfers on a cycle where w_valid_o && w_ready_i; while
// w_valid_o is high and w_ready_i low, w_o/round_o/last_o hold. A block is
// taken on load_i && ready_o && !abort_i; abort_i wins over load and beats.
module sha_msg_schedule
  import sha::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  mode_t              mode_i,
  input  logic               load_i,
  output logic               ready_o,
  input  msg_t               msg_i,
  input  logic               abort_i,
  output logic               w_valid_o,
  input  logic               w_ready_i,
  output logic [LANES*64-1:0] w_o,
  output logic [6:0]         round_o,
  output logic               last_o,
  output logic               err_o
);

  if ((LANES != 1) && (LANES != 2)) begin : g_bad_lanes
    $error("sha_msg_schedule: LANES must be 1 or 2");
  end

  sched_state_t state_q, state_d;
  mode_t        mode_q;
  logic [6:0]   round_q;
  logic         err_q;
  logic [63:0]  win_q   [SCHED_WIN];
  logic [63:0]  load_w  [SCHED_WIN];
  logic [63:0]  shift_w [SCHED_WIN];
  logic [63:0]  new_w   [LANES];
  logic         load_ok, load_bad, beat, last;

  // Block words in order, and the window after a beat (drop LANES, append new words).
  for (genvar i = 0; i < SCHED_WIN; i++) begin : g_win
    assign load_w[i] = is64(mode_i) ? msg_i.w64[15-i] : {32'b0, msg_i.w32[15-i]};
    if (i < SCHED_WIN - LANES) begin : g_keep
      assign shift_w[i] = win_q[i+LANES];
    end else begin : g_new
      assign shift_w[i] = new_w[i-(SCHED_WIN-LANES)];
    end
  end

  // Lane k computes W_(t+16+k) purely from the current window.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [63:0] tap_b, tap_c, tap_d;
`ifdef SHA_SCHED_SHA1_EN
    assign tap_b = (mode_q == SHA1) ? win_q[k+2]  : win_q[k+1];
    assign tap_c = (mode_q == SHA1) ? win_q[k+8]  : win_q[k+9];
    assign tap_d = (mode_q == SHA1) ? win_q[k+13] : win_q[k+14];
`else
    assign tap_b = win_q[k+1];
    assign tap_c = win_q[k+9];
    assign tap_d = win_q[k+14];
`endif
    sha_sched_word u_word (
      .tap_a (win_q[k]),
      .tap_b (tap_b),
      .tap_c (tap_c),
      .tap_d (tap_d),
      .mode  (mode_q),
      .word  (new_w[k])
    );
    assign w_o[64*k +: 64] = win_q[k];
  end

  // Next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    load_ok  = 1'b0;
    load_bad = 1'b0;
    beat     = 1'b0;
    last     = (state_q == RUN) && ((round_q + 7'(LANES)) == rounds(mode_q));
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_i) begin
            if (mode_ok(mode_i)) begin
              load_ok = 1'b1;
              state_d = RUN;
            end else begin
              load_bad = 1'b1;
            end
          end
        end
        RUN: begin
          if (w_ready_i) begin
            beat = 1'b1;
            if (last) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Window, round counter, captured mode and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '{default: '0};
      round_q <= '0;
      mode_q  <= SHA256;
      err_q   <= 1'b0;
    end else begin
      err_q <= load_bad;
      if (abort_i) begin
        round_q <= '0;
      end else if (load_ok) begin
        mode_q  <= mode_i;
        round_q <= '0;
        win_q   <= load_w;
      end else if (beat) begin
        round_q <= last ? 7'd0 : round_q + 7'(LANES);
        win_q   <= shift_w;
      end
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign w_valid_o = (state_q == RUN);
  assign round_o   = round_q;
  assign last_o    = last;
  assign err_o     = err_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: LANES=1 and LANES=2 instances share all inputs
// and are checked every cycle against a full-block W_t model.
module tb_sha_msg_schedule;
  import sha::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mode_t mode_i = SHA256;
  msg_t  msg_i  = '0;
  logic  load_i = 1'b0, abort_i = 1'b0, w_ready_i = 1'b0;

  logic         r1, v1, l1, e1, r2, v2, l2, e2;
  logic [63:0]  w1;
  logic [127:0] w2;
  logic [6:0]   rd1, rd2;

  sha_msg_schedule #(.LANES(1)) u1 (
    .clk(clk), .rst(rst), .mode_i(mode_i), .load_i(load_i), .ready_o(r1),
    .msg_i(msg_i), .abort_i(abort_i), .w_valid_o(v1), .w_ready_i(w_ready_i),
    .w_o(w1), .round_o(rd1), .last_o(l1), .err_o(e1));

  sha_msg_schedule #(.LANES(2)) u2 (
    .clk(clk), .rst(rst), .mode_i(mode_i), .load_i(load_i), .ready_o(r2),
    .msg_i(msg_i), .abort_i(abort_i), .w_valid_o(v2), .w_ready_i(w_ready_i),
    .w_o(w2), .round_o(rd2), .last_o(l2), .err_o(e2));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: full W_t table for the current block ----------------
  logic [63:0] model [80];

  function automatic logic [31:0] rotr32(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rotr64(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic int nrounds(mode_t m);
    return ((m == SHA224) || (m == SHA256)) ? 64 : 80;
  endfunction
  function automatic bit supported(mode_t m);
`ifdef SHA_SCHED_SHA1_EN
    return int'(m) <= 4;
`else
    return (int'(m) >= 1) && (int'(m) <= 4);
`endif
  endfunction

  task automatic compute_model(input mode_t m, input msg_t msg);
    logic [31:0] x, s0, s1;
    logic [63:0] y0, y1;
    bit wide;
    wide = (m == SHA384) || (m == SHA512);
    for (int j = 0; j < 16; j++)
      model[j] = wide ? msg.w64[15-j] : {32'b0, msg.w32[15-j]};
    for (int t = 16; t < 80; t++) begin
      if (m == SHA1) begin
        x = model[t-3][31:0] ^ model[t-8][31:0] ^ model[t-14][31:0] ^ model[t-16][31:0];
        model[t] = {32'b0, x[30:0], x[31]};
      end else if (wide) begin
        y1 = rotr64(model[t-2], 19) ^ rotr64(model[t-2], 61) ^ (model[t-2] >> 6);
        y0 = rotr64(model[t-15], 1) ^ rotr64(model[t-15], 8) ^ (model[t-15] >> 7);
        model[t] = y1 + model[t-7] + y0 + model[t-16];
      end else begin
        s1 = rotr32(model[t-2][31:0], 17) ^ rotr32(model[t-2][31:0], 19) ^ (model[t-2][31:0] >> 10);
        s0 = rotr32(model[t-15][31:0], 7) ^ rotr32(model[t-15][31:0], 18) ^ (model[t-15][31:0] >> 3);
        model[t] = {32'b0, s1 + model[t-7][31:0] + s0 + model[t-16][31:0]};
      end
    end
  endtask

  // ---------------- scoreboard: per-instance expected stream position ----------------
  logic         exp_v   [2] = '{1'b0, 1'b0};
  int           exp_r   [2] = '{0, 0};
  mode_t        exp_m   [2] = '{SHA256, SHA256};
  logic         exp_err [2] = '{1'b0, 1'b0};
  logic         exp_r0  [2] = '{1'b1, 1'b1};
  int           beats   [2] = '{0, 0};
  int           last_rd [2] = '{-1, -1};
  logic         prev_st [2] = '{1'b0, 1'b0};
  logic [127:0] prev_w  [2] = '{128'b0, 128'b0};
  logic [6:0]   prev_rd [2] = '{7'b0, 7'b0};

  task automatic chk(input int id, input int lanes, input logic v, input logic rdy,
                     input logic [127:0] w, input logic [6:0] rd, input logic lst, input logic er);
    int nr;
    nr = nrounds(exp_m[id]);
    check($sformatf("u%0d valid", id), v, exp_v[id]);
    check($sformatf("u%0d ready", id), rdy, !exp_v[id]);
    check($sformatf("u%0d err", id), er, exp_err[id]);
    if (exp_v[id]) begin
      check($sformatf("u%0d round", id), rd, exp_r[id]);
      check($sformatf("u%0d last", id), lst, (exp_r[id] + lanes) == nr);
      for (int k = 0; k < lanes; k++)
        check($sformatf("u%0d W%0d", id, exp_r[id] + k), w[64*k +: 64], model[exp_r[id] + k]);
      if (lst) last_rd[id] = rd;
    end else if (exp_r0[id]) begin
      check($sformatf("u%0d idle round", id), rd, 0);
    end
    if (prev_st[id]) begin
      check($sformatf("u%0d stall w", id), w, prev_w[id]);
      check($sformatf("u%0d stall round", id), rd, prev_rd[id]);
    end
    prev_st[id] = exp_v[id] && !w_ready_i && !abort_i;
    prev_w[id]  = w;
    prev_rd[id] = rd;
    exp_err[id] = 1'b0;
    if (abort_i) begin
      exp_v[id]  = 1'b0;
      exp_r[id]  = 0;
      exp_r0[id] = 1'b1;
    end else if (exp_v[id] && w_ready_i) begin
      beats[id]++;
      exp_r[id] += lanes;
      if (exp_r[id] == nr) begin
        exp_v[id] = 1'b0;
        exp_r[id] = 0;
      end
    end else if (!exp_v[id] && load_i) begin
      if (supported(mode_i)) begin
        exp_v[id]   = 1'b1;
        exp_r[id]   = 0;
        exp_m[id]   = mode_i;
        exp_r0[id]  = 1'b0;
        beats[id]   = 0;
        last_rd[id] = -1;
      end else begin
        exp_err[id] = 1'b1;
      end
    end
  endtask

  task automatic chk_rst(input int id, input logic v, input logic rdy,
                         input logic [127:0] w, input logic [6:0] rd, input logic lst, input logic er);
    check($sformatf("u%0d rst valid", id), v, 0);
    check($sformatf("u%0d rst ready", id), rdy, 1);
    check($sformatf("u%0d rst w", id), w, 0);
    check($sformatf("u%0d rst round", id), rd, 0);
    check($sformatf("u%0d rst last", id), lst, 0);
    check($sformatf("u%0d rst err", id), er, 0);
    exp_v[id] = 1'b0; exp_r[id] = 0; exp_err[id] = 1'b0; exp_r0[id] = 1'b1; prev_st[id] = 1'b0;
  endtask

  // Compare process: every negedge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk_rst(0, v1, r1, {64'b0, w1}, rd1, l1, e1);
      chk_rst(1, v2, r2, w2, rd2, l2, e2);
    end else begin
      chk(0, 1, v1, r1, {64'b0, w1}, rd1, l1, e1);
      chk(1, 2, v2, r2, w2, rd2, l2, e2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input mode_t m, input msg_t msg);
    compute_model(m, msg);
    mode_i = m;
    msg_i  = msg;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  task automatic run_block(input bit stall);
    int n;
    n = 0;
    while ((v1 || v2) && n < 2000) begin
      w_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    w_ready_i = 1'b0;
    check("run timeout", n >= 2000, 0);
  endtask

  task automatic run_to_round(input int target);
    int n;
    n = 0;
    while (!(v1 && rd1 == 7'(target)) && n < 2000) begin
      w_ready_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    w_ready_i = 1'b0;
    check("round wait timeout", n >= 2000, 0);
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    for (int i = 0; i < 32; i++) m.w32[i] = $urandom;
    return m;
  endfunction

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    msg_t m;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset ready", r1, 1);
    check("reset w", w1, 0);
    check("reset valid", v1, 0);

    // sha256 "abc", LANES 1 and 2, random stalls.
    m = '0;
    m.w32[15] = 32'h61626380;
    m.w32[0]  = 32'h00000018;
    compute_model(SHA256, m);
    check("model256 W15", model[15], 64'h18);
    check("model256 W16", model[16], 64'h61626380);
    check("model256 W17", model[17], 64'h000F0000);
    do_load(SHA256, m);
    check("sha256 u1 W0", w1, 64'h61626380);
    check("sha256 u2 W0W1", w2, {64'h0, 64'h61626380});
    run_block(1'b1);
    check("sha256 u1 beats", beats[0], 64);
    check("sha256 u2 beats", beats[1], 32);
    check("sha256 u1 last round", last_rd[0], 63);
    check("sha256 u2 last round", last_rd[1], 62);
    check("sha256 ready after", r1, 1);

    // sha512 "abc".
    m = '0;
    m.w64[15] = 64'h6162638000000000;
    m.w64[0]  = 64'h18;
    compute_model(SHA512, m);
    check("model512 W16", model[16], 64'h6162638000000000);
    do_load(SHA512, m);
    check("sha512 u2 W0W1", w2, {64'h0, 64'h6162638000000000});
    run_block(1'b0);
    check("sha512 u1 beats", beats[0], 80);
    check("sha512 u2 beats", beats[1], 40);
    check("sha512 u1 last round", last_rd[0], 79);
    check("sha512 u2 last round", last_rd[1], 78);

    // sha1 "abc".
    m = '0;
    m.w32[15] = 32'h61626380;
    m.w32[0]  = 32'h00000018;
`ifdef SHA_SCHED_SHA1_EN
    compute_model(SHA1, m);
    check("model sha1 W16", model[16], 64'hC2C4C700);
    do_load(SHA1, m);
    run_block(1'b1);
    check("sha1 u1 beats", beats[0], 80);
    check("sha1 u2 beats", beats[1], 40);
`else
    do_load(SHA1, m);
    check("sha1 err u1", e1, 1);
    check("sha1 err u2", e2, 1);
    check("sha1 no valid", v1, 0);
    tick();
    check("sha1 err one pulse", e1, 0);
    check("sha1 ready", r1, 1);
`endif

    // Unsupported mode 7.
    do_load(mode_t'(3'd7), m);
    check("mode7 err", e1, 1);
    check("mode7 no valid", v2, 0);
    check("mode7 ready", r2, 1);
    tick();
    check("mode7 err one pulse", e1, 0);

    // Random data sha256 and sha384 with stalls.
    do_load(SHA256, rand_msg());
    run_block(1'b1);
    check("rand256 u1 beats", beats[0], 64);
    do_load(SHA384, rand_msg());
    run_block(1'b1);
    check("rand384 u2 beats", beats[1], 40);

    // Abort at round 20 together with a load.
    do_load(SHA256, rand_msg());
    run_to_round(20);
    abort_i = 1'b1;
    load_i  = 1'b1;
    mode_i  = SHA512;
    tick();
    abort_i = 1'b0;
    load_i  = 1'b0;
    check("abort u1 valid", v1, 0);
    check("abort u1 ready", r1, 1);
    check("abort u1 round", rd1, 0);
    check("abort u2 valid", v2, 0);
    tick();
    check("abort load ignored", v1, 0);
    m = '0;
    m.w32[15] = 32'h61626380;
    m.w32[0]  = 32'h00000018;
    do_load(SHA256, m);
    check("restart round", rd1, 0);
    check("restart W0", w1, 64'h61626380);
    run_block(1'b1);
    check("restart beats", beats[0], 64);

    // Reset in the middle of a stream.
    do_load(SHA256, rand_msg());
    run_to_round(10);
    rst = 1'b1;
    #1;
    check("midrst valid", v1, 0);
    check("midrst round", rd1, 0);
    check("midrst w", w1, 0);
    check("midrst ready", r1, 1);
    tick();
    rst = 1'b0;
    tick();
    do_load(SHA224, rand_msg());
    run_block(1'b0);
    check("post-reset beats", beats[0], 64);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sha_msg_schedule.md
Name: sha_msg_schedule

Overview:
- Streaming message-schedule generator for the SHA core; sits between the block loader and the compression round logic.
- Accepts one padded message block and emits W_t for every round, LANES words per beat, over a valid/ready handshake.
- Covers sha224/sha256 (32-bit words, 64 rounds) and sha384/sha512 (64-bit words, 80 rounds); sha1 (80 rounds) is optional.
- Uses a 16-word sliding window with shared delta0/delta1 arithmetic.

Parameters:
- LANES, 1, schedule words produced per beat; legal values are 1 or 2 (elaboration error otherwise).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mode_i  in  3  sha::mode_t, sampled with the load.
- load_i  in  1  block load request.
- ready_o  out  1  block can be accepted; equals (state==IDLE).
- msg_i  in  1024  sha::msg_t block.
- abort_i  in  1  synchronous flush to IDLE.
- w_valid_o  out  1  schedule beat valid.
- w_ready_i  in  1  consumer accepts beat.
- w_o  out  LANES*64  lane k in bits [64k+63:64k] = W_(t+k); 32-bit modes zero-extended in the upper 32 bits of each lane.
- round_o  out  7  t of lane 0.
- last_o  out  1  beat contains the final round word.
- err_o  out  1  one-cycle pulse on an unsupported mode load.

Behaviour:
- Reset values: state IDLE, w_valid_o=0, w_o=0, round_o=0, last_o=0, err_o=0, window=0; ready_o=1.
- States are IDLE and RUN.
- Load acceptance:
  - A load is accepted when load_i && ready_o && !abort_i.
  - Supported mode: the window is loaded, the state goes to RUN, and W_0 is presented with w_valid_o=1 on the next cycle (latency 1).
  - Unsupported mode (values 5-7, or sha1 without the macro): the block is consumed, err_o pulses next cycle, the state stays IDLE, and w_valid_o stays 0.
- Word mapping:
  - 32-bit modes: W_j = msg_i.w32[15-j] for j=0..15; msg_i.w32[31:16] are ignored.
  - 64-bit modes: W_j = msg_i.w64[15-j].
- Window:
  - win[0..15] holds W_t..W_(t+15).
  - Lane k outputs win[k] (a registered output).
  - On each accepted beat the window shifts by LANES and the new words W_(t+16+k) are appended.
- Recurrence:
  - SHA-2: W_(n+16) = delta1(W_(n+14)) + W_(n+9) + delta0(W_(n+1)) + W_n, modulo 2^32 or 2^64 per mode.
  - SHA-1: W_(n+16) = rotl1(W_(n+13) ^ W_(n+8) ^ W_(n+2) ^ W_n).
  - With LANES=2, W_(t+17) is computed from existing window entries only (no dependency on W_(t+16)).
- Handshake:
  - While w_valid_o && !w_ready_i, w_o, round_o and last_o hold stable.
  - round_o advances by LANES per accepted beat.
  - last_o=1 when round_o+LANES equals the round count (64 or 80).
- Completion:
  - When the last beat is accepted, the next cycle has w_valid_o=0 and state IDLE, so ready_o=1.
  - There is no back-to-back overlap of blocks.
- Abort:
  - abort_i in any state: next cycle state IDLE, w_valid_o=0, round_o=0.
  - abort_i has priority over load_i and over beat acceptance in the same cycle.
- Reset mid-RUN: immediate return to reset values; the partial stream is discarded.

Optional Feature:
- Macro SHA_SCHED_SHA1_EN.
- Defined: mode sha1 is supported with the rotl1 recurrence, 80 rounds, 32-bit words.
- Undefined: sha1 is an unsupported mode (err_o pulse, no stream) and the SHA-1 XOR/rotate logic is not built.

Decomposition:
- Additions to package sha:
  - Round-count function rounds(mode_t) returning 64 or 80.
  - is64(mode_t).
  - Constant SCHED_WIN=16.
  - Existing delta0_32/64 and delta1_32/64 are reused.
- Sub-module sha_sched_word: combinational next-word calculator (inputs: four window taps, mode; output: 64-bit word), instantiated once per lane.

Test Plan:
- sha256, LANES=1, "abc" block (w32[15]=0x61626380, w32[0]=0x00000018, rest 0) -> W0=0x61626380, W15=0x18, W16=0x61626380, W17=0x000F0000; 64 beats, last_o on round 63, ready_o=1 the following cycle.
- sha512, LANES=2, "abc" (w64[15]=0x6162638000000000, w64[0]=0x18) -> beat 0 lanes {W0, W1}={0x6162638000000000, 0}; W16=0x6162638000000000; 40 beats, last_o on round_o=78.
- sha1 with SHA_SCHED_SHA1_EN, "abc" -> W16=0xC2C4C700, 80 beats.
- sha1 without the macro, or mode=7 -> err_o pulses once, no w_valid_o, ready_o stays 1.
- Random w_ready_i stalls on sha256 -> output words match a golden model; w_o is stable during every stall.
- abort_i asserted at round 20, together with load_i -> IDLE next cycle, load ignored; a subsequent load restarts cleanly at round 0.
